// File: rtl/debug_loader_pkg.sv
// Command bytes and FSM state encoding shared by the debug loader and the UART-side reporter.
package debug_loader_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_PCRST = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_LEN  = 3'd1,
    ST_LOAD_DATA = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4
  } state_t;

endpackage

// File: rtl/debug_loader.sv
// UART-driven program loader and PC run/step controller for the fetch stage.
module debug_loader
  import debug_loader_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_IM_DEPTH = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_DATA-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_halt,
  output logic                   o_im_enable,
  output logic                   o_im_write_enable,
  output logic [NB_DATA-1:0]     o_im_write_data,
  output logic [NB_IM_DEPTH-1:0] o_im_write_addr,
  output logic                   o_read_enable,
  output logic                   o_pc_reset,
  output logic                   o_pc_enable,
  output logic                   o_load_done,
  output logic                   o_cmd_error,
  output logic                   o_idle
);

  localparam int CW = NB_IM_DEPTH + 1;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic [NB_IM_DEPTH-1:0] addr, addr_next;
  logic                   we_next, done_next, err_next, pcrst_cmd;
  logic [NB_DATA-1:0]     wdata_next;
  logic [NB_IM_DEPTH-1:0] waddr_next;
  logic                   loading_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = addr;
    we_next    = 1'b0;
    wdata_next = o_im_write_data;
    waddr_next = o_im_write_addr;
    done_next  = 1'b0;
    err_next   = 1'b0;
    pcrst_cmd  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == NB_DATA'(CMD_LOAD))       state_next = ST_LOAD_LEN;
          else if (i_rx_data == NB_DATA'(CMD_RUN))   state_next = ST_RUN;
          else if (i_rx_data == NB_DATA'(CMD_STEP))  state_next = ST_STEP;
          else if (i_rx_data == NB_DATA'(CMD_PCRST)) pcrst_cmd  = 1'b1;
          else                                       err_next   = 1'b1;
        end
      end
      ST_LOAD_LEN: begin
        if (i_rx_done) begin
          // A length byte of zero encodes a full-memory load.
          cnt_next   = (i_rx_data == '0) ? (CW'(1) << NB_IM_DEPTH) : CW'(i_rx_data);
          addr_next  = '0;
          state_next = ST_LOAD_DATA;
        end
      end
      ST_LOAD_DATA: begin
        if (i_rx_done) begin
          we_next    = 1'b1;
          wdata_next = i_rx_data;
          waddr_next = addr;
          addr_next  = addr + 1'b1;
          cnt_next   = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (i_halt) state_next = ST_IDLE;
      end
      ST_STEP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    loading_next = (state_next == ST_LOAD_LEN) || (state_next == ST_LOAD_DATA);
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      addr              <= '0;
      o_im_enable       <= 1'b0;
      o_im_write_enable <= 1'b0;
      o_im_write_data   <= '0;
      o_im_write_addr   <= '0;
      o_read_enable     <= 1'b0;
      o_pc_reset        <= 1'b0;
      o_pc_enable       <= 1'b0;
      o_load_done       <= 1'b0;
      o_cmd_error       <= 1'b0;
      o_idle            <= 1'b1;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      addr              <= addr_next;
      o_im_enable       <= 1'b1;
      o_im_write_enable <= we_next;
      o_im_write_data   <= wdata_next;
      o_im_write_addr   <= waddr_next;
      o_read_enable     <= !loading_next;
      o_pc_reset        <= loading_next || pcrst_cmd;
      o_pc_enable       <= (state_next == ST_RUN) || (state_next == ST_STEP);
      o_load_done       <= done_next;
      o_cmd_error       <= err_next;
      o_idle            <= (state_next == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Self-checking bench for debug_loader: command vector table plus a write scoreboard.
module tb_debug_loader;
  import debug_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       halt;
  logic       im_enable, im_we, read_enable, pc_reset, pc_enable, load_done, cmd_error, idle;
  logic [7:0] im_wdata, im_waddr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;
  wr_t sb[$];

  // {pc_enable, pc_reset, cmd_error, idle} one and two cycles after the strobe
  typedef struct {
    logic [7:0] cmd;
    logic [3:0] exp1;
    logic [3:0] exp2;
  } vec_t;
  vec_t vec[8];

  debug_loader #(.NB_DATA(8), .NB_IM_DEPTH(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done), .i_halt(halt),
    .o_im_enable(im_enable), .o_im_write_enable(im_we), .o_im_write_data(im_wdata),
    .o_im_write_addr(im_waddr), .o_read_enable(read_enable), .o_pc_reset(pc_reset),
    .o_pc_enable(pc_enable), .o_load_done(load_done), .o_cmd_error(cmd_error), .o_idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one cycle, then compare any write strobe against the scoreboard head.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (im_we === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        w = sb.pop_front();
        chk("write_addr", im_waddr, w.addr);
        chk("write_data", im_wdata, w.data);
        chk("load_done_on_write", load_done, w.done);
      end
    end else if (load_done !== 1'b0) begin
      chk("load_done_without_write", load_done, 0);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d, input logic dn);
    wr_t w;
    w.addr = a; w.data = d; w.done = dn;
    sb.push_back(w);
  endtask

  task automatic load(input int n, input logic [7:0] seed);
    send(CMD_LOAD);
    chk("load_len_pc_reset", pc_reset, 1);
    chk("load_len_read_enable", read_enable, 0);
    send(8'(n));
    for (int i = 0; i < ((n == 0) ? 256 : n); i++) begin
      logic [7:0] d;
      d = 8'(i) ^ seed;
      expect_write(8'(i), d, (i == ((n == 0) ? 255 : n - 1)));
      send(d);
      if (idle === 1'b0) chk("load_pc_reset", pc_reset, 1);
      chk("load_pc_enable", pc_enable, 0);
    end
    tick();
    chk("load_back_to_idle", idle, 1);
    chk("load_sb_drained", sb.size(), 0);
  endtask

  initial begin
    vec[0] = '{CMD_STEP,  4'b1000, 4'b0001};
    vec[1] = '{CMD_STEP,  4'b1000, 4'b0001};
    vec[2] = '{CMD_STEP,  4'b1000, 4'b0001};
    vec[3] = '{CMD_PCRST, 4'b0101, 4'b0001};
    vec[4] = '{8'h7A,     4'b0011, 4'b0001};
    vec[5] = '{8'h00,     4'b0011, 4'b0001};
    vec[6] = '{8'hFF,     4'b0011, 4'b0001};
    vec[7] = '{8'h6C,     4'b0011, 4'b0001};

    rst = 1'b1; rx_data = '0; rx_done = 1'b0; halt = 1'b0;
    tick(); tick();
    chk("rst_idle", idle, 1);
    chk("rst_im_enable", im_enable, 0);
    chk("rst_read_enable", read_enable, 0);
    chk("rst_strobes", {im_we, pc_reset, pc_enable, load_done, cmd_error}, 0);
    chk("rst_addr_data", {im_waddr, im_wdata}, 0);
    rst = 1'b0;
    tick();
    chk("idle_im_enable", im_enable, 1);
    chk("idle_read_enable", read_enable, 1);
    chk("idle_flag", idle, 1);
    chk("idle_strobes", {im_we, pc_reset, pc_enable, load_done, cmd_error}, 0);

    for (int i = 0; i < 8; i++) begin
      send(vec[i].cmd);
      chk($sformatf("vec%0d_t1", i), {pc_enable, pc_reset, cmd_error, idle}, vec[i].exp1);
      tick();
      chk($sformatf("vec%0d_t2", i), {pc_enable, pc_reset, cmd_error, idle}, vec[i].exp2);
      tick();
    end

    // Four-byte back-to-back load
    send(CMD_LOAD);
    send(8'h04);
    expect_write(8'h00, 8'h11, 1'b0);
    expect_write(8'h01, 8'h22, 1'b0);
    expect_write(8'h02, 8'h33, 1'b0);
    expect_write(8'h03, 8'h44, 1'b1);
    send(8'h11); chk("l4_pc_reset0", pc_reset, 1);
    send(8'h22); chk("l4_pc_reset1", pc_reset, 1);
    send(8'h33); chk("l4_pc_reset2", pc_reset, 1);
    send(8'h44); chk("l4_idle_after_last", idle, 1);
    tick();
    chk("l4_sb_drained", sb.size(), 0);
    chk("l4_no_extra_done", load_done, 0);

    // Full 256-byte load with length byte 0
    load(0, 8'h5A);
    load(3, 8'hC3);

    // Continuous run, halted after ten cycles; stray bytes ignored
    send(CMD_RUN);
    for (int k = 1; k < 10; k++) begin
      chk($sformatf("run_pc_enable_t%0d", k), pc_enable, 1);
      chk("run_not_idle", idle, 0);
      rx_data = CMD_LOAD;
      rx_done = (k == 3);
      tick();
      rx_done = 1'b0;
    end
    chk("run_pc_enable_t10", pc_enable, 1);
    halt = 1'b1; rx_data = CMD_STEP; rx_done = 1'b1;
    tick();
    halt = 1'b0; rx_done = 1'b0;
    chk("halt_pc_enable_off", pc_enable, 0);
    chk("halt_idle", idle, 1);
    tick();
    chk("halt_byte_dropped", {pc_enable, idle}, 2'b01);

    // Step while halt is already high still pulses
    halt = 1'b1;
    send(CMD_STEP);
    chk("step_halted_pulse", pc_enable, 1);
    tick();
    chk("step_halted_end", {pc_enable, idle}, 2'b01);
    halt = 1'b0;

    // Reset after the second of four data bytes
    send(CMD_LOAD);
    send(8'h04);
    expect_write(8'h00, 8'hA1, 1'b0);
    expect_write(8'h01, 8'hA2, 1'b0);
    send(8'hA1);
    send(8'hA2);
    rst = 1'b1; rx_data = 8'hA3; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("midrst_no_write", im_we, 0);
    chk("midrst_idle", idle, 1);
    rst = 1'b0;
    tick();
    chk("midrst_after_no_write", im_we, 0);
    chk("midrst_read_enable", read_enable, 1);
    chk("midrst_sb_drained", sb.size(), 0);
    load(2, 8'hE0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/debug_loader.md
# debug_loader

Upstream control block for the fetch stage. It consumes a byte stream from the UART receiver, writes program bytes into instruction memory, and drives PC reset/enable for continuous-run and single-step execution. It is the sole driver of the fetch stage's instruction-memory write port and PC control inputs.

## Interface
- NB_DATA, 8, width of UART byte and instruction-memory write data
- NB_IM_DEPTH, 8, instruction-memory byte-address width (256 bytes)
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  received byte; valid only when i_rx_done=1
- i_rx_done  in  1  one-cycle strobe per received byte
- i_halt  in  1  level from pipeline; halt instruction has retired
- o_im_enable  out  1  instruction-memory enable
- o_im_write_enable  out  1  one-cycle byte-write strobe
- o_im_write_data  out  NB_DATA  byte to write
- o_im_write_addr  out  NB_IM_DEPTH  byte address to write
- o_read_enable  out  1  instruction-memory read enable
- o_pc_reset  out  1  hold PC at 0
- o_pc_enable  out  1  PC advance enable
- o_load_done  out  1  one-cycle pulse when the last program byte is written
- o_cmd_error  out  1  one-cycle pulse on an unknown command byte
- o_idle  out  1  FSM is in IDLE

## Operation
- Command bytes are accepted only in IDLE: 0x4C 'L' load, 0x43 'C' run, 0x53 'S' step, 0x52 'R' PC reset. Any other byte in IDLE pulses o_cmd_error and the FSM stays in IDLE.
- States: IDLE, LOAD_LEN, LOAD_DATA, RUN, STEP.
- IDLE: 'L' -> LOAD_LEN; 'C' -> RUN; 'S' -> STEP; 'R' -> pulse o_pc_reset for one cycle and stay in IDLE.
- LOAD_LEN: the next byte N is the byte count, with N=0 meaning 256. Load the counter with N, clear the address to 0, and go to LOAD_DATA.
- LOAD_DATA: each strobe writes i_rx_data at the current address, then increments the address (wraps 255->0 without error) and decrements the count. When the count reaches 0, pulse o_load_done on the same cycle as the final write strobe, then go to IDLE.
- While in LOAD_LEN and LOAD_DATA: o_pc_reset=1, o_pc_enable=0, o_read_enable=0.
- RUN: o_pc_enable=1 every cycle until i_halt=1 is sampled, then go to IDLE. o_pc_enable is 0 from the cycle after the sample. i_rx_done is ignored in RUN.
- STEP: o_pc_enable=1 for exactly one cycle, then go to IDLE. If i_halt is already 1, STEP still issues its pulse; the pipeline's halt logic governs the effect.
- o_read_enable=1 in IDLE, RUN and STEP. o_im_enable=1 in every state after reset.
- o_idle=1 exactly when in IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - o_im_enable, o_im_write_enable, o_pc_reset, o_pc_enable, o_load_done, o_cmd_error, o_read_enable = 0
  - o_im_write_data and o_im_write_addr = 0
  - o_idle = 1
- From the first cycle after reset is released, o_im_enable=1 and o_read_enable=1.
- Write latency: a strobe at cycle t gives o_im_write_enable=1 at t+1, with data and address stable for that cycle.
- Strobes on consecutive cycles must each be written; there is no back-pressure.
- Command latency: a strobe with 'C' or 'S' at t gives o_pc_enable=1 at t+1.
- Reset asserted mid-load or mid-run: the FSM returns to IDLE next edge and all counters clear. No partial write strobe may follow the reset cycle.
- i_halt and a byte strobe in the same RUN cycle: halt wins and the byte is dropped.

## Structure
- Shared header/package holds the command byte constants (CMD_LOAD, CMD_RUN, CMD_STEP, CMD_PCRST) and the state encoding, reused by the UART-side TX reporter.
- Single module, no sub-modules. The byte counter and address counter are internal registers (roughly 150–250 lines).

## Test plan
- Reset, then idle: o_idle=1, o_im_enable=1, o_read_enable=1, all strobes 0.
- 'L', 0x04, then 0x11, 0x22, 0x33, 0x44 back-to-back: four write strobes at addresses 0–3 with matching data, o_load_done on the write of 0x44, o_pc_reset=1 throughout, then IDLE.
- 'L', 0x00, then 256 bytes: the address wraps to 0 after 255 and o_load_done fires on the 256th write.
- 'C' at t: o_pc_enable=1 from t+1. i_halt=1 at t+10 gives o_pc_enable=0 from t+11 and o_idle=1. A byte sent during RUN is ignored.
- 'S' three times: three isolated one-cycle o_pc_enable pulses. 'R' gives a one-cycle o_pc_reset. Byte 0x7A gives an o_cmd_error pulse and stays IDLE.
- i_reset asserted after the 2nd data byte of a 4-byte load: no further writes, IDLE. A new 'L' restarts at address 0.
